// File: rtl/alu_exec_pkg.sv
// Shared definitions for the execute-stage ALU: operation bit positions,
// controller states and the one-hot legality check on the decoder enables.
package alu_exec_pkg;

    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_MUL  = 2;
    localparam int OP_DIV  = 3;
    localparam int OP_MOD  = 4;
    localparam int OP_MAX  = 5;
    localparam int OP_MIN  = 6;
    localparam int OP_NOT  = 7;
    localparam int OP_NAND = 8;
    localparam int OP_XNOR = 9;
    localparam int OP_SHL  = 10;
    localparam int OP_SHRL = 11;
    localparam int OP_ROL  = 12;
    localparam int OP_ROR  = 13;
    localparam int OP_SLT  = 14;
    localparam int NUM_OPS = 15;

    // Operations that go through the iterative multiply/divide engine.
    localparam logic [NUM_OPS-1:0] MD_MASK =
        (NUM_OPS'(1) << OP_MUL) | (NUM_OPS'(1) << OP_DIV) | (NUM_OPS'(1) << OP_MOD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_onehot(input logic [NUM_OPS-1:0] v);
        return (v != '0) && ((v & (v - NUM_OPS'(1))) == '0);
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between operand fetch, the ALU and writeback.
// A transfer happens on a rising edge where valid & ready are both high;
// a valid source keeps its payload stable until that edge, and ready may depend on state only.
interface alu_exec_unit_if #(parameter int WIDTH = 16);
    import alu_exec_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [NUM_OPS-1:0]   op_en;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     result;
    logic                 err;
    logic                 dbz;

    modport master (
        output in_valid, op_en, a, b, out_ready,
        input  in_ready, out_valid, result, err, dbz
    );

    modport slave (
        input  in_valid, op_en, a, b, out_ready,
        output in_ready, out_valid, result, err, dbz
    );

endinterface

// File: rtl/alu_iter_muldiv.sv
// One-bit-per-cycle shift-add multiplier and restoring divider sharing a
// WIDTH-cycle counter; operands load on start, done marks the final iteration.
module alu_iter_muldiv #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(WIDTH);

    logic          busy;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // Partial remainder stays below the divisor, so bit WIDTH of the trial
    // difference is a clean borrow flag; a zero divisor never borrows.
    assign shifted = {remainder, quotient[WIDTH-1]};
    assign trial   = shifted - {1'b0, divisor};
    assign done    = busy && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            cnt       <= '0;
            product   <= '0;
            mcand     <= '0;
            mplier    <= '0;
            divisor   <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (start) begin
            busy      <= 1'b1;
            cnt       <= '0;
            product   <= '0;
            mcand     <= a;
            mplier    <= b;
            divisor   <= b;
            quotient  <= a;
            remainder <= '0;
        end else if (busy) begin
            if (mplier[0]) begin
                product <= product + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (!trial[WIDTH]) begin
                remainder <= trial[WIDTH-1:0];
                quotient  <= {quotient[WIDTH-2:0], 1'b1};
            end else begin
                remainder <= shifted[WIDTH-1:0];
                quotient  <= {quotient[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt + CW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ops resolve on accept, MUL/DIV/MOD run in
// the iterative engine; the result is held in DONE until writeback takes it.
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_exec_unit_if.slave       bus,
    output state_t               dbg_state
);
    localparam int SHW = $clog2(WIDTH);

    state_t state_q, state_d;
    logic   accept, in_ready, legal, is_md;
    logic   md_start, md_done;
    logic   md_q, mul_q, div_q, err_q, dbz_q;
    logic [WIDTH-1:0]   result_q, simple_res, md_res;
    logic [WIDTH-1:0]   product, quotient, remainder;
    logic [2*WIDTH-1:0] rot_l, rot_r;
    logic [SHW-1:0]     shamt;
    logic               lt;

    assign legal    = is_onehot(bus.op_en);
    assign is_md    = |(bus.op_en & MD_MASK);
    assign md_start = accept && legal && is_md;
    assign shamt    = bus.b[SHW-1:0];
    assign lt       = $signed(bus.a) < $signed(bus.b);
    assign rot_l    = {bus.a, bus.a} << shamt;
    assign rot_r    = {bus.a, bus.a} >> shamt;

    always_comb begin
        simple_res = '0;
        case (1'b1)
            bus.op_en[OP_ADD]:  simple_res = bus.a + bus.b;
            bus.op_en[OP_SUB]:  simple_res = bus.a - bus.b;
            bus.op_en[OP_MAX]:  simple_res = lt ? bus.b : bus.a;
            bus.op_en[OP_MIN]:  simple_res = lt ? bus.a : bus.b;
            bus.op_en[OP_NOT]:  simple_res = ~bus.a;
            bus.op_en[OP_NAND]: simple_res = ~(bus.a & bus.b);
            bus.op_en[OP_XNOR]: simple_res = ~(bus.a ^ bus.b);
            bus.op_en[OP_SHL]:  simple_res = bus.a << shamt;
            bus.op_en[OP_SHRL]: simple_res = bus.a >> shamt;
            bus.op_en[OP_ROL]:  simple_res = rot_l[2*WIDTH-1:WIDTH];
            bus.op_en[OP_ROR]:  simple_res = rot_r[WIDTH-1:0];
            bus.op_en[OP_SLT]:  simple_res = {{(WIDTH-1){1'b0}}, lt};
            default:            simple_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        accept   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = !rst;
                if (bus.in_valid && !rst) begin
                    accept  = 1'b1;
                    state_d = (legal && is_md) ? BUSY : DONE;
                end
            end
            BUSY:    if (md_done) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            err_q    <= 1'b0;
            dbz_q    <= 1'b0;
            md_q     <= 1'b0;
            mul_q    <= 1'b0;
            div_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                result_q <= legal ? simple_res : '0;
                err_q    <= !legal;
                dbz_q    <= legal && (bus.op_en[OP_DIV] || bus.op_en[OP_MOD]) && (bus.b == '0);
                md_q     <= legal && is_md;
                mul_q    <= bus.op_en[OP_MUL];
                div_q    <= bus.op_en[OP_DIV];
            end
        end
    end

    alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk       (clk),
        .rst       (rst),
        .start     (md_start),
        .a         (bus.a),
        .b         (bus.b),
        .done      (md_done),
        .product   (product),
        .quotient  (quotient),
        .remainder (remainder)
    );

    // Iterative results stay in the engine registers, which are frozen once done.
    assign md_res        = mul_q ? product : (div_q ? quotient : remainder);
    assign bus.result    = md_q ? md_res : result_q;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == DONE);
    assign bus.err       = err_q;
    assign bus.dbz       = dbz_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed pinned cases, backpressure, mid-operation
// reset and randomized operations against an arithmetic reference model.
module tb_alu_exec_unit;
    import alu_exec_pkg::*;

    localparam int W = 16;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    state_t dbg_state;

    alu_exec_unit_if #(.WIDTH(W)) bus();

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] exp_q[$];
    logic         exp_err_q[$];
    logic         exp_dbz_q[$];
    logic [W-1:0] last_res;
    logic         last_err;
    logic         last_dbz;
    bit           hold_ready = 1'b0;
    bit           rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [NUM_OPS-1:0] op_bit(input int i);
        logic [NUM_OPS-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Reference model: plain arithmetic straight from the operation definitions.
    function automatic void model(input logic [NUM_OPS-1:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] r,
                                  output logic e, output logic z);
        int unsigned s;
        logic [2*W-1:0] p;
        s = b % W;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        r = '0;
        e = 1'b0;
        z = 1'b0;
        if ($countones(op) != 1) begin
            e = 1'b1;
            return;
        end
        case (1'b1)
            op[OP_ADD]:  r = a + b;
            op[OP_SUB]:  r = a - b;
            op[OP_MUL]:  r = p[W-1:0];
            op[OP_DIV]:  begin r = (b == 0) ? '1 : a / b; z = (b == 0); end
            op[OP_MOD]:  begin r = (b == 0) ? a : a % b;  z = (b == 0); end
            op[OP_MAX]:  r = ($signed(a) > $signed(b)) ? a : b;
            op[OP_MIN]:  r = ($signed(a) < $signed(b)) ? a : b;
            op[OP_NOT]:  r = ~a;
            op[OP_NAND]: r = ~(a & b);
            op[OP_XNOR]: r = ~(a ^ b);
            op[OP_SHL]:  r = a << s;
            op[OP_SHRL]: r = a >> s;
            op[OP_ROL]:  r = (a << s) | (a >> (W - s));
            op[OP_ROR]:  r = (a >> s) | (a << (W - s));
            op[OP_SLT]:  r = ($signed(a) < $signed(b)) ? 1 : 0;
            default:     r = '0;
        endcase
    endfunction

    // scoreboard compare: every cycle a result is presented
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                check("result", bus.result, exp_q[0]);
                check("err", bus.err, exp_err_q[0]);
                check("dbz", bus.dbz, exp_dbz_q[0]);
                check("in_ready_in_done", bus.in_ready, 0);
                if (bus.out_ready) begin
                    last_res = bus.result;
                    last_err = bus.err;
                    last_dbz = bus.dbz;
                    void'(exp_q.pop_front());
                    void'(exp_err_q.pop_front());
                    void'(exp_dbz_q.pop_front());
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (hold_ready)      bus.out_ready = 1'b0;
        else if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
        else                 bus.out_ready = 1'b1;
    end

    // mode 0: no result expected; 1: expect result, check latency; 2: also wait for handshake
    task automatic issue(input logic [NUM_OPS-1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int mode);
        logic [W-1:0] r;
        logic e, z;
        int n, lat, exp_lat;
        model(op, a, b, r, e, z);
        exp_lat = (!e && (op[OP_MUL] || op[OP_DIV] || op[OP_MOD])) ? W + 1 : 1;
        @(posedge clk);
        #1;
        bus.op_en = op;
        bus.a = a;
        bus.b = b;
        bus.in_valid = 1'b1;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 200) begin
                check("accept_timeout", 0, 1);
                bus.in_valid = 1'b0;
                return;
            end
        end
        if (mode != 0) begin
            exp_q.push_back(r);
            exp_err_q.push_back(e);
            exp_dbz_q.push_back(z);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        bus.op_en = NUM_OPS'($urandom);
        if (mode == 0) return;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 100);
        check("latency", lat, exp_lat);
        if (mode == 1) return;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("handshake_timeout", 0, 1);
            exp_q.delete();
            exp_err_q.delete();
            exp_dbz_q.delete();
        end
    endtask

    task automatic pinned(input string name, input logic [NUM_OPS-1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] pin_res,
                          input logic pin_err, input logic pin_dbz);
        issue(op, a, b, 2);
        check(name, last_res, pin_res);
        check("pin_err", last_err, pin_err);
        check("pin_dbz", last_dbz, pin_dbz);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1);
    end

    initial begin
        logic [W-1:0] ra, rb;
        logic [NUM_OPS-1:0] rop;
        bit seen;
        bus.in_valid  = 1'b0;
        bus.op_en     = '0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_result", bus.result, 0);
        check("rst_err", bus.err, 0);
        check("rst_dbz", bus.dbz, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_state", dbg_state, IDLE);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", bus.in_ready, 1);

        pinned("add_wrap", op_bit(OP_ADD), 16'h7FFF, 16'h0001, 16'h8000, 0, 0);
        pinned("sub_wrap", op_bit(OP_SUB), 16'h0000, 16'h0001, 16'hFFFF, 0, 0);
        pinned("mul", op_bit(OP_MUL), 16'd300, 16'd200, 16'hEA60, 0, 0);
        pinned("div", op_bit(OP_DIV), 16'd1000, 16'd7, 16'd142, 0, 0);
        pinned("mod", op_bit(OP_MOD), 16'd1000, 16'd7, 16'd6, 0, 0);
        pinned("div_zero", op_bit(OP_DIV), 16'd1234, 16'd0, 16'hFFFF, 0, 1);
        pinned("mod_zero", op_bit(OP_MOD), 16'd1234, 16'd0, 16'd1234, 0, 1);
        pinned("min", op_bit(OP_MIN), 16'hFFFE, 16'd3, 16'hFFFE, 0, 0);
        pinned("max", op_bit(OP_MAX), 16'hFFFE, 16'd3, 16'd3, 0, 0);
        pinned("slt", op_bit(OP_SLT), 16'hFFFE, 16'd3, 16'd1, 0, 0);
        pinned("ror", op_bit(OP_ROR), 16'h0001, 16'h0011, 16'h8000, 0, 0);
        pinned("rol_zero", op_bit(OP_ROL), 16'h8001, 16'h0010, 16'h8001, 0, 0);
        pinned("shrl", op_bit(OP_SHRL), 16'h8000, 16'd15, 16'h0001, 0, 0);
        pinned("shl", op_bit(OP_SHL), 16'h00F1, 16'd4, 16'h0F10, 0, 0);
        pinned("nand", op_bit(OP_NAND), 16'hF0F0, 16'hFF00, 16'h0FFF, 0, 0);
        pinned("illegal_zero", 15'h0000, 16'd5, 16'd6, 16'h0000, 1, 0);
        pinned("illegal_two", 15'h0003, 16'd5, 16'd6, 16'h0000, 1, 0);

        for (int i = 0; i < NUM_OPS; i++) begin
            issue(op_bit(i), W'($urandom), W'($urandom), 2);
        end

        // backpressure: result and in_ready frozen while writeback stalls
        hold_ready = 1'b1;
        issue(op_bit(OP_ADD), 16'h7FFF, 16'h0001, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_out_valid", bus.out_valid, 1);
            check("hold_result", bus.result, 16'h8000);
            check("hold_in_ready", bus.in_ready, 0);
        end
        hold_ready = 1'b0;
        repeat (4) @(negedge clk);
        check("hold_drained", exp_q.size(), 0);

        // reset while the multiplier is iterating
        issue(op_bit(OP_MUL), 16'd300, 16'd200, 0);
        repeat (5) @(negedge clk);
        check("mul_busy_state", dbg_state, BUSY);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("postrst_in_ready", bus.in_ready, 1);
        check("postrst_out_valid", bus.out_valid, 0);
        check("postrst_result", bus.result, 0);
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("no_stale_result", seen, 0);

        rand_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 99) < 85) rop = op_bit($urandom_range(0, NUM_OPS - 1));
            else rop = NUM_OPS'($urandom_range(0, 32767));
            ra = W'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 20));
                default: rb = W'($urandom);
            endcase
            issue(rop, ra, rb, 2);
        end
        rand_ready = 1'b0;

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Multi-cycle ALU datapath that consumes the 15 one-hot operation enables produced by the opcode decoder, and returns a result through a valid/ready handshake. Simple operations complete in one cycle. MUL, DIV and MOD run iteratively, one bit per cycle. The block sits in the execute stage between operand fetch and writeback.

Parameters:
WIDTH, 16, operand and result width in bits; must be a power of two, 8 or larger.
SHW, log2(WIDTH), shift/rotate amount width; derived, not overridable.

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operation request valid
in_ready  output  1  unit can accept a request
op_en  input  15  one-hot enables; bit0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 5 MAX, 6 MIN, 7 NOT, 8 NAND, 9 XNOR, 10 SHL, 11 SHRL, 12 ROL, 13 ROR, 14 SLT
a  input  WIDTH  operand A
b  input  WIDTH  operand B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  operation result
err  output  1  op_en was not one-hot (zero bits or more than one bit set)
dbz  output  1  divide or modulo by zero

Behaviour:
- Reset: state IDLE. out_valid, result, err and dbz are all 0. in_ready is 0 while rst is high. Reset mid-operation aborts the operation and no result is produced.
- FSM states:
  - IDLE: in_ready=1. An accept is in_valid & in_ready. Operands and op_en are registered on accept.
  - Accept of MUL, DIV or MOD goes to BUSY. Every other accept, including an illegal op_en, goes to DONE.
  - BUSY: iteration counter runs 0..WIDTH-1. After the WIDTH-th iteration the state goes to DONE.
  - DONE: out_valid=1, and result/err/dbz are held stable. out_valid & out_ready returns to IDLE.
  - in_ready=0 in BUSY and DONE, so there is no accept in the cycle of the output handshake.
- Latency from accept edge to out_valid:
  - Single-cycle ops: 1 cycle.
  - MUL, DIV, MOD: WIDTH+1 cycles.
- Arithmetic:
  - ADD/SUB: modulo 2^WIDTH; carry and borrow are discarded.
  - MUL: lower WIDTH bits of the product, using shift-add over WIDTH cycles.
  - DIV/MOD: unsigned restoring division over WIDTH cycles.
  - MAX, MIN, SLT: signed two's complement. SLT returns 1 if a<b, else 0, zero-extended.
  - NOT: ~a. NAND: ~(a&b). XNOR: ~(a^b).
  - SHL/SHRL: logical shift of a by b[SHW-1:0]; upper bits of b are ignored.
  - ROL/ROR: rotate a by b[SHW-1:0]. An amount of 0 returns a.
- Divide by zero (b==0 on DIV/MOD):
  - The op still takes WIDTH+1 cycles.
  - DIV returns all ones; MOD returns a; dbz=1.
- Illegal op_en (popcount != 1): accepted, DONE after 1 cycle with result=0, err=1, dbz=0.
- err and dbz are 0 for every legal, nonzero-divisor operation.
- Inputs are ignored when in_valid=0 or in_ready=0. Operand changes during BUSY have no effect.
- out_valid held with out_ready low for any number of cycles: outputs stay unchanged.

Decomposition:
- Package alu_exec_pkg:
  - Op bit-index localparams (OP_ADD=0 .. OP_SLT=14) and NUM_OPS=15.
  - FSM state enum {IDLE, BUSY, DONE}.
  - One-hot check function.
- Sub-module alu_iter_muldiv:
  - Holds the shift-add/restoring-divide datapath, the WIDTH-cycle counter, and start/done pulses.
  - Produces the product low half, quotient and remainder.

Test Plan:
- ADD a=16'h7FFF, b=1 -> out_valid 1 cycle after accept, result 16'h8000, err=0. SUB a=0, b=1 -> 16'hFFFF.
- MUL a=300, b=200 -> result 16'hEA60 (60000 mod 2^16) exactly 17 cycles after accept. DIV a=1000, b=7 -> 142. MOD a=1000, b=7 -> 6.
- DIV a=1234, b=0 -> result 16'hFFFF, dbz=1. MOD a=1234, b=0 -> result 1234, dbz=1.
- Signed ops, each op_en bit in turn:
  - MIN a=16'hFFFE(-2), b=3 -> 16'hFFFE.
  - SLT same operands -> 1.
  - ROR a=16'h0001, b=16'h0011 (amount 1) -> 16'h8000.
  - SHRL a=16'h8000, b=15 -> 1.
- op_en=0 -> result 0, err=1 after 1 cycle. op_en=15'h0003 -> same. in_ready must be 0 while DONE.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0.
  - Assert rst during BUSY of a MUL -> next cycle out_valid=0, in_ready=1 after rst drops, no stale result.
